hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It takes decoded source-register usage from ID, destination and load information from EX, branch/jump redirect from EX, and data-memory busy. It then drives the per-stage write enables and flushes: load-use stalls, redirect flushes and memory-wait holds. It also keeps saturating stall/flush performance counters for debug CSRs.

Parameters:
FLUSH_CYCLES, 1, extra cycles after a redirect cycle during which IF/ID and ID/EX stay flushed (fetch latency); legal 0..7
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX stage holds a real instruction
ex_rd  in  5  EX destination register
ex_memread  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch / JAL / JALR
dmem_busy  in  1  data memory not ready; MEM must hold
pc_we  out  1  PC register write enable
ifid_we  out  1  IF/ID register write enable
ifid_flush  out  1  IF/ID loads a bubble
idex_flush  out  1  ID/EX loads a bubble
exmem_we  out  1  EX/MEM and MEM/WB write enable
state  out  2  0 RUN, 1 FLUSH, 2 MEM_WAIT
stall_cnt  out  CNT_W  cycles with pc_we=0 outside reset, saturating
flush_cnt  out  CNT_W  redirects accepted, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n. Sampled low at a clk edge: state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0.
- Enables and flushes are combinational from the registered state and current inputs. State and counters are registered.
- While rst_n=0: pc_we=ifid_we=exmem_we=0, ifid_flush=idex_flush=1, regardless of state.
- lu (load-use) = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Default outputs: pc_we=ifid_we=exmem_we=1, flushes=0.
- RUN or MEM_WAIT, evaluated with this priority:
  - dmem_busy: pc_we=ifid_we=exmem_we=0, flushes=0; next=MEM_WAIT. All stages are frozen, so a coincident ex_redirect persists and is acted on the cycle busy drops.
  - ex_redirect: pc_we=1, ifid_flush=1, idex_flush=1; flush_cnt+1; next=FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>0, else RUN.
  - lu: pc_we=0, ifid_we=0, idex_flush=1 (one bubble); next=RUN. The bubble clears lu next cycle, giving a 1-cycle penalty.
  - Otherwise: defaults; next=RUN.
- FLUSH state:
  - dmem_busy: all enables 0, flushes 0; fcnt held; stay FLUSH.
  - ex_redirect: treated as a new redirect (flush_cnt+1, fcnt reloaded).
  - Otherwise: defaults plus ifid_flush=idex_flush=1; lu ignored. If fcnt==0, next=RUN; else fcnt-1.
- stall_cnt increments in every cycle with rst_n=1 and pc_we=0. Both counters hold at all-ones.
- Reset mid-FLUSH or mid-MEM_WAIT returns to RUN; no pending redirect is retained.
- Illegal state encoding 3 behaves as RUN and next=RUN.

Test Plan:
- Load-use: EX lw x5 (ex_memread=1, ex_rd=5), ID add rs1=5 use_rs1=1 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle defaults; stall_cnt=1.
- x0 / unused source: ex_rd=0, or id_use_rs2=0 with rs2 match -> no stall, stall_cnt stays 0.
- Redirect, FLUSH_CYCLES=1: ex_redirect one cycle -> that cycle and the next have ifid_flush=idex_flush=1, pc_we=1; state RUN->FLUSH->RUN; flush_cnt=1.
- dmem_busy 3 cycles with ex_redirect held -> 3 cycles all enables 0, state=MEM_WAIT, stall_cnt=3; 4th cycle redirect taken, flush_cnt=1.
- Reset mid-FLUSH (FLUSH_CYCLES=3, rst_n low at 2nd flush cycle) -> next cycle state=RUN, counters 0, defaults after rst_n high.
- Saturation, CNT_W=2: 5 consecutive load-use stalls -> stall_cnt sticks at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes and
// memory-wait holds for the 5-stage core, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0]       FCNT_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       redirect_take;
  logic       lu;

  assign lu = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Illegal encoding 3 falls into the default arm and behaves as RUN.
  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    exmem_we      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    redirect_take = 1'b0;
    state_d       = ST_RUN;
    fcnt_d        = fcnt_q;

    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      exmem_we   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      fcnt_d     = 3'd0;
    end else if (dmem_busy) begin
      // Whole pipe frozen; a coincident redirect is acted on once busy drops.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      state_d  = (state_q == ST_FLUSH) ? ST_FLUSH : ST_MEM_WAIT;
    end else if (ex_redirect) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      redirect_take = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d = ST_FLUSH;
        fcnt_d  = FCNT_LOAD;
      end
    end else if (state_q == ST_FLUSH) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (fcnt_q != 3'd0) begin
        state_d = ST_FLUSH;
        fcnt_d  = fcnt_q - 3'd1;
      end
    end else if (lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_take && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
